// File: rtl/pu_layer_sequencer.sv
// pu_layer_sequencer: multi-layer PU loop controller. Holds a writable
// per-layer config table and, for each layer, walks the oc/ic/row loops
// issuing one vecgen read request per loop point, with optional pooling
// drain, abort and sticky reserved-type error.
module pu_layer_sequencer #(
  parameter int unsigned NUM_LAYERS        = 16,
  parameter int unsigned LAYER_PARAM_WIDTH = 10,
  parameter int unsigned STRIDE_SIZE_W     = 3,
  parameter int unsigned L_TYPE_WIDTH      = 2,
  parameter int unsigned LAYER_W           = $clog2(NUM_LAYERS),
  parameter int unsigned CFG_WIDTH         = L_TYPE_WIDTH + 1 + STRIDE_SIZE_W + 4 * LAYER_PARAM_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         cfg_wr_en,
  input  logic [LAYER_W-1:0]           cfg_wr_addr,
  input  logic [CFG_WIDTH-1:0]         cfg_wr_data,
  input  logic [LAYER_W-1:0]           num_layers_m1,
  input  logic                         start,
  input  logic                         abort,
  input  logic                         pu_ready,
  input  logic                         rd_ready,
  input  logic                         pool_done,
  output logic                         rd_req,
  output logic                         busy,
  output logic                         layer_start,
  output logic                         layer_done,
  output logic                         done,
  output logic                         err,
  output logic [LAYER_W-1:0]           layer_idx,
  output logic [LAYER_PARAM_WIDTH-1:0] cur_oc,
  output logic [LAYER_PARAM_WIDTH-1:0] cur_ic,
  output logic [LAYER_PARAM_WIDTH-1:0] cur_row,
  output logic [L_TYPE_WIDTH-1:0]      l_type,
  output logic [LAYER_PARAM_WIDTH-1:0] kh_m1,
  output logic [STRIDE_SIZE_W-1:0]     stride,
  output logic                         pool
);

  localparam int unsigned PW     = LAYER_PARAM_WIDTH;
  localparam int unsigned SW     = STRIDE_SIZE_W;
  localparam int unsigned KH_LSB = 0;
  localparam int unsigned IH_LSB = PW;
  localparam int unsigned IC_LSB = 2 * PW;
  localparam int unsigned OC_LSB = 3 * PW;
  localparam int unsigned ST_LSB = 4 * PW;
  localparam int unsigned PL_BIT = 4 * PW + SW;
  localparam int unsigned LT_LSB = 4 * PW + SW + 1;

  localparam logic [L_TYPE_WIDTH-1:0] LT_CONV = L_TYPE_WIDTH'(0);
  localparam logic [L_TYPE_WIDTH-1:0] LT_NORM = L_TYPE_WIDTH'(2);
  localparam logic [L_TYPE_WIDTH-1:0] LT_RSVD = L_TYPE_WIDTH'(3);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CFG  = 3'd1;
  localparam logic [2:0] S_WAIT = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_POOL = 3'd4;
  localparam logic [2:0] S_NEXT = 3'd5;
  localparam logic [2:0] S_FIN  = 3'd6;

  logic [2:0]              state_q, state_d;
  logic [CFG_WIDTH-1:0]    cfg_tbl_q [NUM_LAYERS];
  logic [CFG_WIDTH-1:0]    cfg_rd;
  logic [LAYER_W-1:0]      nl_q, nl_d;
  logic [LAYER_W-1:0]      idx_q, idx_d;
  logic                    err_q, err_d;
  logic                    ls_q, ls_d;
  logic                    ld_q, ld_d;
  logic [L_TYPE_WIDTH-1:0] lt_q, lt_d;
  logic                    pool_q, pool_d;
  logic [SW-1:0]           stride_q, stride_d;
  logic [PW-1:0]           kh_q, kh_d;
  logic [PW-1:0]           ih_q, ih_d;
  logic [PW-1:0]           icm_q, icm_d;
  logic [PW-1:0]           ocm_q, ocm_d;
  logic [PW-1:0]           row_q, row_d;
  logic [PW-1:0]           ic_q, ic_d;
  logic [PW-1:0]           oc_q, oc_d;
  logic [PW:0]             step;
  logic [PW:0]             row_sum;
  logic                    xfer;
  logic                    row_wrap;
  logic                    ic_wrap;
  logic                    oc_wrap;

  assign cfg_rd = cfg_tbl_q[idx_q];
  assign xfer   = rd_req && rd_ready;

  // Config table: writable only while idle; contents are not reset.
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && cfg_wr_en) begin
      cfg_tbl_q[cfg_wr_addr] <= cfg_wr_data;
    end
  end

  // Row step (stride 0 behaves as 1) and the widened row sum used for the wrap test.
  always_comb begin
    step = '0;
    step[SW-1:0] = stride_q;
    if (stride_q == '0) begin
      step = (PW+1)'(1);
    end
    row_sum = {1'b0, row_q} + step;
  end

  // Loop wrap conditions; collapsed loops (row for IP/norm, ic for norm) always wrap.
  always_comb begin
    row_wrap = 1'b1;
    if (lt_q == LT_CONV) begin
      row_wrap = row_sum > {1'b0, ih_q};
    end
    ic_wrap = row_wrap && ((lt_q == LT_NORM) || (ic_q == icm_q));
    oc_wrap = ic_wrap && (oc_q == ocm_q);
  end

  // Sequencer next-state: abort overrides every other transition.
  always_comb begin
    state_d  = state_q;
    nl_d     = nl_q;
    idx_d    = idx_q;
    err_d    = err_q;
    ls_d     = 1'b0;
    ld_d     = 1'b0;
    lt_d     = lt_q;
    pool_d   = pool_q;
    stride_d = stride_q;
    kh_d     = kh_q;
    ih_d     = ih_q;
    icm_d    = icm_q;
    ocm_d    = ocm_q;
    row_d    = row_q;
    ic_d     = ic_q;
    oc_d     = oc_q;
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_CFG;
            nl_d    = num_layers_m1;
            idx_d   = '0;
            err_d   = 1'b0;
          end
        end
        S_CFG: begin
          lt_d     = cfg_rd[LT_LSB +: L_TYPE_WIDTH];
          pool_d   = cfg_rd[PL_BIT];
          stride_d = cfg_rd[ST_LSB +: SW];
          ocm_d    = cfg_rd[OC_LSB +: PW];
          icm_d    = cfg_rd[IC_LSB +: PW];
          ih_d     = cfg_rd[IH_LSB +: PW];
          kh_d     = cfg_rd[KH_LSB +: PW];
          row_d    = '0;
          ic_d     = '0;
          oc_d     = '0;
          if (cfg_rd[LT_LSB +: L_TYPE_WIDTH] == LT_RSVD) begin
            err_d   = 1'b1;
            state_d = S_NEXT;
          end else begin
            ls_d    = 1'b1;
            state_d = S_WAIT;
          end
        end
        S_WAIT: begin
          if (pu_ready) begin
            state_d = S_RUN;
          end
        end
        S_RUN: begin
          if (xfer) begin
            if (!row_wrap) begin
              row_d = row_sum[PW-1:0];
            end else begin
              row_d = '0;
              if (!ic_wrap) begin
                ic_d = ic_q + PW'(1);
              end else begin
                ic_d = '0;
                if (!oc_wrap) begin
                  oc_d = oc_q + PW'(1);
                end else begin
                  oc_d    = '0;
                  ld_d    = 1'b1;
                  state_d = pool_q ? S_POOL : S_NEXT;
                end
              end
            end
          end
        end
        S_POOL: begin
          if (pool_done) begin
            state_d = S_NEXT;
          end
        end
        S_NEXT: begin
          if (idx_q == nl_q) begin
            state_d = S_FIN;
          end else begin
            idx_d   = idx_q + LAYER_W'(1);
            state_d = S_CFG;
          end
        end
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= S_IDLE;
      nl_q     <= '0;
      idx_q    <= '0;
      err_q    <= 1'b0;
      ls_q     <= 1'b0;
      ld_q     <= 1'b0;
      lt_q     <= '0;
      pool_q   <= 1'b0;
      stride_q <= '0;
      kh_q     <= '0;
      ih_q     <= '0;
      icm_q    <= '0;
      ocm_q    <= '0;
      row_q    <= '0;
      ic_q     <= '0;
      oc_q     <= '0;
    end else begin
      state_q  <= state_d;
      nl_q     <= nl_d;
      idx_q    <= idx_d;
      err_q    <= err_d;
      ls_q     <= ls_d;
      ld_q     <= ld_d;
      lt_q     <= lt_d;
      pool_q   <= pool_d;
      stride_q <= stride_d;
      kh_q     <= kh_d;
      ih_q     <= ih_d;
      icm_q    <= icm_d;
      ocm_q    <= ocm_d;
      row_q    <= row_d;
      ic_q     <= ic_d;
      oc_q     <= oc_d;
    end
  end

  // Request is masked by abort so an aborting cycle can never complete a transfer.
  assign rd_req      = (state_q == S_RUN) && !abort;
  assign busy        = (state_q != S_IDLE);
  assign layer_start = ls_q;
  assign layer_done  = ld_q;
  assign done        = (state_q == S_FIN);
  assign err         = err_q;
  assign layer_idx   = idx_q;
  assign cur_oc      = oc_q;
  assign cur_ic      = ic_q;
  assign cur_row     = row_q;
  assign l_type      = lt_q;
  assign kh_m1       = kh_q;
  assign stride      = stride_q;
  assign pool        = pool_q;

endmodule

// File: tb/tb_pu_layer_sequencer.sv
// Self-checking bench for pu_layer_sequencer: nested-loop reference model of
// the expected request stream plus pulse/timing checks per scenario.
module tb_pu_layer_sequencer;
  localparam int NL = 16;
  localparam int PW = 10;
  localparam int SW = 3;
  localparam int TW = 2;
  localparam int LW = 4;
  localparam int CW = TW + 1 + SW + 4 * PW;

  typedef struct packed {
    logic [LW-1:0] l;
    logic [PW-1:0] oc;
    logic [PW-1:0] ic;
    logic [PW-1:0] row;
  } xfer_t;

  logic clk = 1'b0;
  logic reset, cfg_wr_en, start, abort, pu_ready, rd_ready, pool_done;
  logic [LW-1:0] cfg_wr_addr, num_layers_m1;
  logic [CW-1:0] cfg_wr_data;
  logic rd_req, busy, layer_start, layer_done, done, err, pool;
  logic [LW-1:0] layer_idx;
  logic [PW-1:0] cur_oc, cur_ic, cur_row, kh_m1;
  logic [TW-1:0] l_type;
  logic [SW-1:0] stride;

  always #5 clk = ~clk;

  pu_layer_sequencer #(
    .NUM_LAYERS(NL), .LAYER_PARAM_WIDTH(PW), .STRIDE_SIZE_W(SW), .L_TYPE_WIDTH(TW)
  ) dut (
    .clk(clk), .reset(reset), .cfg_wr_en(cfg_wr_en), .cfg_wr_addr(cfg_wr_addr),
    .cfg_wr_data(cfg_wr_data), .num_layers_m1(num_layers_m1), .start(start), .abort(abort),
    .pu_ready(pu_ready), .rd_ready(rd_ready), .pool_done(pool_done), .rd_req(rd_req),
    .busy(busy), .layer_start(layer_start), .layer_done(layer_done), .done(done), .err(err),
    .layer_idx(layer_idx), .cur_oc(cur_oc), .cur_ic(cur_ic), .cur_row(cur_row),
    .l_type(l_type), .kh_m1(kh_m1), .stride(stride), .pool(pool)
  );

  logic [CW-1:0] tbl [NL];
  xfer_t obs[$];
  xfer_t exp_q[$];
  int ls_cyc[$];
  int ld_cyc[$];
  int n_checks = 0;
  int n_errors = 0;
  int n_ls, n_ld, n_dn, dn_cyc, last_xfer_cyc;
  bit timeout_hit, aborted;

  function automatic logic [CW-1:0] mk_cfg(input logic [1:0] lt, input logic pl, input logic [2:0] st,
                                           input logic [9:0] oc, input logic [9:0] ic,
                                           input logic [9:0] ih, input logic [9:0] kh);
    return {lt, pl, st, oc, ic, ih, kh};
  endfunction

  // Reference model: enumerate every loop point of every layer with plain nested loops.
  task automatic build_model(input int nl, output bit e, output int nrun);
    logic [CW-1:0] w;
    int lt, st, oc, ic, ih, s, rh, ch;
    xfer_t x;
    exp_q.delete();
    e = 0;
    nrun = 0;
    for (int L = 0; L <= nl; L++) begin
      w  = tbl[L];
      lt = int'(w[45:44]); st = int'(w[42:40]);
      oc = int'(w[39:30]); ic = int'(w[29:20]); ih = int'(w[19:10]);
      if (lt == 3) begin e = 1; continue; end
      nrun++;
      s  = (st == 0) ? 1 : st;
      rh = (lt == 0) ? ih : 0;
      ch = (lt == 2) ? 0 : ic;
      for (int o = 0; o <= oc; o++)
        for (int i = 0; i <= ch; i++)
          for (int r = 0; r <= rh; r += s) begin
            x.l = LW'(L); x.oc = PW'(o); x.ic = PW'(i); x.row = PW'(r);
            exp_q.push_back(x);
          end
    end
  endtask

  task automatic write_cfg(input logic [LW-1:0] a, input logic [CW-1:0] d);
    cfg_wr_en = 1'b1; cfg_wr_addr = a; cfg_wr_data = d;
    @(posedge clk); #1;
    cfg_wr_en = 1'b0;
    tbl[a] = d;
  endtask

  // Stimulus driver/monitor: starts a run, drives ready/pool/abort/noise, records what it sees.
  task automatic run_seq(input int max_cyc, input int rmode, input int pool_dly,
                         input int abort_at, input int start_at, input bit noise);
    int cyc, pc;
    bit fin, in_pool, start_sent, abort_now;
    obs.delete(); ls_cyc.delete(); ld_cyc.delete();
    n_ls = 0; n_ld = 0; n_dn = 0; dn_cyc = -1; last_xfer_cyc = -1;
    timeout_hit = 0; aborted = 0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cyc = 0; fin = 0; in_pool = 0; pc = 0; start_sent = 0;
    while (!fin && cyc < max_cyc) begin
      case (rmode)
        0: rd_ready = 1'b1;
        1: rd_ready = (cyc % 2 == 0);
        default: rd_ready = 1'($urandom_range(0, 1));
      endcase
      pu_ready = (rmode == 2) ? 1'($urandom_range(0, 1)) : 1'b1;
      if (layer_done) begin in_pool = 1; pc = 0; end
      if (in_pool) begin
        pool_done = (pc == pool_dly - 1);
        if (pool_done) in_pool = 0;
        pc++;
      end else begin
        pool_done = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      end
      abort_now = (abort_at > 0) && (obs.size() == abort_at - 1) && rd_req;
      abort = abort_now;
      start = (start_at > 0) && !start_sent && (obs.size() == start_at) && busy;
      if (start) start_sent = 1;
      if (noise && busy) begin
        cfg_wr_en = 1'($urandom_range(0, 1));
        cfg_wr_addr = LW'($urandom);
        cfg_wr_data = CW'({$urandom, $urandom});
      end else begin
        cfg_wr_en = 1'b0;
      end
      @(negedge clk);
      if (rd_req && rd_ready) begin
        obs.push_back({layer_idx, cur_oc, cur_ic, cur_row});
        last_xfer_cyc = cyc;
      end
      if (layer_start) begin n_ls++; ls_cyc.push_back(cyc); end
      if (layer_done) begin n_ld++; ld_cyc.push_back(cyc); end
      if (done) begin n_dn++; dn_cyc = cyc; fin = 1; end
      if (abort_now) begin aborted = 1; fin = 1; end
      @(posedge clk); #1;
      cyc++;
    end
    if (!fin) timeout_hit = 1;
    start = 0; abort = 0; pool_done = 0; cfg_wr_en = 0; rd_ready = 0; pu_ready = 0;
  endtask

  task automatic test_reset();
    reset = 1'b0; cfg_wr_en = 0; cfg_wr_addr = '0; cfg_wr_data = '0; num_layers_m1 = '0;
    start = 0; abort = 0; pu_ready = 0; rd_ready = 0; pool_done = 0;
    repeat (3) @(posedge clk);
    #1;
    n_checks++; if ({rd_req, busy, done, err} !== 4'b0) begin n_errors++; $display("FAIL reset_ctrl: got %b required 0000", {rd_req, busy, done, err}); end
    n_checks++; if ({layer_start, layer_done} !== 2'b0) begin n_errors++; $display("FAIL reset_pulses: got %b required 00", {layer_start, layer_done}); end
    n_checks++; if ({layer_idx, cur_oc, cur_ic, cur_row} !== '0) begin n_errors++; $display("FAIL reset_counters: got %h required 0", {layer_idx, cur_oc, cur_ic, cur_row}); end
    n_checks++; if ({l_type, kh_m1, stride, pool} !== '0) begin n_errors++; $display("FAIL reset_config: got %h required 0", {l_type, kh_m1, stride, pool}); end
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single_conv();
    bit e; int nr; logic [9:0] kh;
    kh = 10'($urandom_range(0, 1023));
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd1, 10'd1, 10'd1, 10'd3, kh));
    num_layers_m1 = 4'd0;
    build_model(0, e, nr);
    run_seq(400, 0, 1, 0, 0, 0);
    n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL conv1_timeout: done not seen, required within 400 cycles"); end
    n_checks++; if (obs.size() != 16) begin n_errors++; $display("FAIL conv1_count: got %0d required 16", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL conv1_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
    n_checks++; if (n_ls != 1 || n_ld != 1 || n_dn != 1) begin n_errors++; $display("FAIL conv1_pulses: got ls=%0d ld=%0d dn=%0d required 1 1 1", n_ls, n_ld, n_dn); end
    if (ld_cyc.size() > 0) begin
      n_checks++; if (ld_cyc[0] != last_xfer_cyc + 1) begin n_errors++; $display("FAIL conv1_ld_time: got cycle %0d required %0d", ld_cyc[0], last_xfer_cyc + 1); end
      n_checks++; if (dn_cyc != ld_cyc[0] + 1) begin n_errors++; $display("FAIL conv1_done_time: got cycle %0d required %0d", dn_cyc, ld_cyc[0] + 1); end
    end
    n_checks++; if ({l_type, kh_m1, stride, pool, err, busy} !== {2'd0, kh, 3'd1, 1'b0, 1'b0, 1'b0}) begin n_errors++; $display("FAIL conv1_cfg_out: got %h required %h", {l_type, kh_m1, stride, pool, err, busy}, {2'd0, kh, 3'd1, 1'b0, 1'b0, 1'b0}); end
  endtask

  task automatic test_stride2();
    bit e; int nr;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd2, 10'd1, 10'd1, 10'd3, 10'd2));
    num_layers_m1 = 4'd0;
    build_model(0, e, nr);
    run_seq(400, 1, 1, 0, 0, 0);
    n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL stride2_timeout: done not seen, required within 400 cycles"); end
    n_checks++; if (obs.size() != 8) begin n_errors++; $display("FAIL stride2_count: got %0d required 8", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL stride2_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
  endtask

  task automatic test_multi_layer();
    bit e; int nr;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd1, 10'd1, 10'd1, 10'd3, 10'd0));
    write_cfg(4'd1, mk_cfg(2'd1, 1'b0, 3'd1, 10'd2, 10'd1, 10'd5, 10'd0));
    write_cfg(4'd2, mk_cfg(2'd2, 1'b0, 3'd1, 10'd3, 10'd2, 10'd4, 10'd0));
    num_layers_m1 = 4'd2;
    build_model(2, e, nr);
    run_seq(2000, 2, 1, 0, 0, 1);
    n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL multi_timeout: done not seen, required within 2000 cycles"); end
    n_checks++; if (obs.size() != 26) begin n_errors++; $display("FAIL multi_count: got %0d required 26", obs.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL multi_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
    n_checks++; if (n_ls != 3 || n_ld != 3 || n_dn != 1) begin n_errors++; $display("FAIL multi_pulses: got ls=%0d ld=%0d dn=%0d required 3 3 1", n_ls, n_ld, n_dn); end
    n_checks++; if (layer_idx !== 4'd2) begin n_errors++; $display("FAIL multi_final_idx: got %0d required 2", layer_idx); end
  endtask

  task automatic test_pool();
    bit e; int nr;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b1, 3'd1, 10'd0, 10'd0, 10'd1, 10'd0));
    write_cfg(4'd1, mk_cfg(2'd2, 1'b0, 3'd1, 10'd1, 10'd0, 10'd0, 10'd0));
    num_layers_m1 = 4'd1;
    build_model(1, e, nr);
    run_seq(400, 0, 5, 0, 0, 1);
    n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL pool_timeout: done not seen, required within 400 cycles"); end
    n_checks++; if (obs.size() != exp_q.size()) begin n_errors++; $display("FAIL pool_count: got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL pool_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
    n_checks++;
    if (ls_cyc.size() != 2 || ld_cyc.size() != 2) begin
      n_errors++; $display("FAIL pool_pulses: got ls=%0d ld=%0d required 2 2", ls_cyc.size(), ld_cyc.size());
    end else if (ls_cyc[1] - ld_cyc[0] != 7) begin
      n_errors++; $display("FAIL pool_gap: got %0d cycles from layer_done to next layer_start, required 7", ls_cyc[1] - ld_cyc[0]);
    end
  endtask

  task automatic test_err_layer();
    bit e; int nr;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd0, 10'd0, 10'd1, 10'd2, 10'd0));
    write_cfg(4'd1, mk_cfg(2'd3, 1'b1, 3'd1, 10'd2, 10'd2, 10'd2, 10'd0));
    write_cfg(4'd2, mk_cfg(2'd1, 1'b0, 3'd1, 10'd1, 10'd1, 10'd0, 10'd0));
    num_layers_m1 = 4'd2;
    build_model(2, e, nr);
    run_seq(2000, 2, 1, 0, 0, 0);
    n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL err_timeout: done not seen, required within 2000 cycles"); end
    n_checks++; if (err !== 1'b1) begin n_errors++; $display("FAIL err_flag: got %b required 1", err); end
    n_checks++; if (obs.size() != exp_q.size()) begin n_errors++; $display("FAIL err_count: got %0d required %0d", obs.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL err_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
    n_checks++; if (n_ls != 2 || n_ld != 2 || n_dn != 1) begin n_errors++; $display("FAIL err_pulses: got ls=%0d ld=%0d dn=%0d required 2 2 1", n_ls, n_ld, n_dn); end
  endtask

  task automatic test_random();
    bit e; int nr, nl, r;
    for (int it = 0; it < 8; it++) begin
      nl = $urandom_range(0, 3);
      for (int L = 0; L <= nl; L++) begin
        r = $urandom_range(0, 7);
        write_cfg(LW'(L), mk_cfg((r == 7) ? 2'd3 : 2'(r % 3), 1'($urandom_range(0, 1)),
                  3'($urandom_range(0, 3)), 10'($urandom_range(0, 2)), 10'($urandom_range(0, 2)),
                  10'($urandom_range(0, 5)), 10'($urandom_range(0, 1023))));
      end
      num_layers_m1 = LW'(nl);
      build_model(nl, e, nr);
      run_seq(3000, 2, $urandom_range(1, 4), 0, 0, 1);
      n_checks++; if (timeout_hit) begin n_errors++; $display("FAIL rand%0d_timeout: done not seen, required within 3000 cycles", it); end
      n_checks++; if (obs.size() != exp_q.size()) begin n_errors++; $display("FAIL rand%0d_count: got %0d required %0d", it, obs.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs.size(); i++) begin
        n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL rand%0d_xfer[%0d]: got %h required %h", it, i, obs[i], exp_q[i]); end
      end
      n_checks++; if (n_ls != nr || n_ld != nr || n_dn != 1) begin n_errors++; $display("FAIL rand%0d_pulses: got ls=%0d ld=%0d dn=%0d required %0d %0d 1", it, n_ls, n_ld, n_dn, nr, nr); end
      n_checks++; if (err !== e || layer_idx !== LW'(nl)) begin n_errors++; $display("FAIL rand%0d_final: got err=%b idx=%0d required err=%b idx=%0d", it, err, layer_idx, e, nl); end
    end
  endtask

  task automatic test_abort();
    bit e; int nr, bad;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd1, 10'd1, 10'd1, 10'd3, 10'd9));
    num_layers_m1 = 4'd0;
    build_model(0, e, nr);
    run_seq(400, 0, 1, 7, 3, 0);
    n_checks++; if (!aborted) begin n_errors++; $display("FAIL abort_issued: abort point not reached, required before done"); end
    n_checks++; if ({busy, rd_req} !== 2'b00) begin n_errors++; $display("FAIL abort_idle: got busy,rd_req=%b required 00", {busy, rd_req}); end
    n_checks++; if (obs.size() != 6) begin n_errors++; $display("FAIL abort_count: got %0d required 6", obs.size()); end
    for (int i = 0; i < 6 && i < obs.size(); i++) begin
      n_checks++; if (obs[i] !== exp_q[i]) begin n_errors++; $display("FAIL abort_xfer[%0d]: got %h required %h", i, obs[i], exp_q[i]); end
    end
    n_checks++; if ({cur_oc, cur_ic, cur_row} !== {exp_q[6].oc, exp_q[6].ic, exp_q[6].row}) begin n_errors++; $display("FAIL abort_counters: got %h required %h", {cur_oc, cur_ic, cur_row}, {exp_q[6].oc, exp_q[6].ic, exp_q[6].row}); end
    n_checks++; if ({l_type, kh_m1, stride, err} !== {2'd0, 10'd9, 3'd1, 1'b0}) begin n_errors++; $display("FAIL abort_cfg_hold: got %h required %h", {l_type, kh_m1, stride, err}, {2'd0, 10'd9, 3'd1, 1'b0}); end
    bad = n_ld + n_dn;
    repeat (6) begin
      @(negedge clk);
      if (done || layer_done || busy) bad++;
    end
    @(posedge clk); #1;
    n_checks++; if (bad != 0) begin n_errors++; $display("FAIL abort_quiet: got %0d done/layer_done/busy events required 0", bad); end
  endtask

  task automatic test_async_reset();
    int n;
    write_cfg(4'd0, mk_cfg(2'd0, 1'b0, 3'd1, 10'd1, 10'd1, 10'd3, 10'd5));
    num_layers_m1 = 4'd0;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; rd_ready = 1'b1; pu_ready = 1'b1;
    n = 0;
    for (int k = 0; k < 50 && n < 4; k++) begin
      @(negedge clk);
      if (rd_req) n++;
    end
    n_checks++; if (n < 4) begin n_errors++; $display("FAIL areset_setup: got %0d requests required 4", n); end
    @(posedge clk); #3;
    reset = 1'b0;
    #1;
    n_checks++; if ({rd_req, busy} !== 2'b00) begin n_errors++; $display("FAIL areset_ctrl: got rd_req,busy=%b required 00", {rd_req, busy}); end
    n_checks++; if ({layer_idx, cur_oc, cur_ic, cur_row, l_type, kh_m1, stride} !== '0) begin n_errors++; $display("FAIL areset_state: got %h required 0", {layer_idx, cur_oc, cur_ic, cur_row, l_type, kh_m1, stride}); end
    rd_ready = 1'b0; pu_ready = 1'b0;
    #3;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    test_reset();
    test_single_conv();
    test_stride2();
    test_multi_layer();
    test_pool();
    test_err_layer();
    test_random();
    test_abort();
    test_async_reset();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
